// File: rtl/stack_pkg.sv
// Shared state encoding and debug LED mapping for the stacking-game sequencer.
package stack_pkg;

  localparam int unsigned STATE_CNT = 12;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_ARM      = 4'd1,
    S_DRAW     = 4'd2,
    S_TICK_RST = 4'd3,
    S_WAIT     = 4'd4,
    S_CHECK    = 4'd5,
    S_HOLD     = 4'd6,
    S_ERASE    = 4'd7,
    S_LOAD     = 4'd8,
    S_NEXT_ROW = 4'd9,
    S_WIN      = 4'd10,
    S_LOSE     = 4'd11
  } state_e;

  // One-hot debug view of a state: bit index equals the enum value.
  function automatic logic [STATE_CNT-1:0] state_led_f(input state_e s);
    return STATE_CNT'(1) << s;
  endfunction

endpackage

// File: rtl/stack_tick_timer.sv
// Row-dependent move period and the tick counter that times block movement.
module stack_tick_timer #(
  parameter int unsigned FRAME_TICKS = 2_500_000,
  parameter int unsigned TICK_STEP   = 250_000,
  parameter int unsigned MIN_TICKS   = 500_000,
  parameter int unsigned ROW_W       = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             en,
  input  logic [ROW_W-1:0] row,
  output logic             expire_c
);

  localparam int unsigned PMAX = (FRAME_TICKS > MIN_TICKS) ? FRAME_TICKS : MIN_TICKS;
  localparam int unsigned TW   = $clog2(PMAX + 1);

  logic [63:0]   dec;
  logic [63:0]   diff;
  logic [63:0]   period;
  logic [TW-1:0] cnt;

  // Period = max(FRAME_TICKS - row*TICK_STEP, MIN_TICKS), clamped before subtracting.
  always_comb begin
    dec    = 64'(row) * 64'(TICK_STEP);
    diff   = (dec >= 64'(FRAME_TICKS)) ? 64'd0 : (64'(FRAME_TICKS) - dec);
    period = (diff < 64'(MIN_TICKS)) ? 64'(MIN_TICKS) : diff;
  end

  // Expiry fires on the last count of the period while counting is enabled.
  always_comb begin
    expire_c = en && (64'(cnt) == (period - 64'd1));
  end

  // Tick counter: cleared on request, advances while enabled.
  always_ff @(posedge clk) begin
    if (resetn || clear) begin
      cnt <= '0;
    end else if (en && !expire_c) begin
      cnt <= cnt + TW'(1);
    end
  end

endmodule

// File: rtl/stack_sequencer.sv
// Control FSM for the stacking game: draw, move timing, drop/check, erase, reload.
module stack_sequencer
  import stack_pkg::*;
#(
  parameter int unsigned BLOCK_PIXELS = 16,
  parameter int unsigned FRAME_TICKS  = 2_500_000,
  parameter int unsigned TICK_STEP    = 250_000,
  parameter int unsigned MIN_TICKS    = 500_000,
  parameter int unsigned ROWS         = 8
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            start,
  input  logic                            drop,
  input  logic                            miss,
  input  logic                            load_done,
  output logic [$clog2(BLOCK_PIXELS)-1:0] pix_idx,
  output logic                            write_en,
  output logic                            erase,
  output logic                            ld_xy,
  output logic [$clog2(ROWS+1)-1:0]       row,
  output logic                            win,
  output logic                            lose,
  output logic [STATE_CNT-1:0]            state_led
);

  localparam int unsigned PIX_W = $clog2(BLOCK_PIXELS);
  localparam int unsigned ROW_W = $clog2(ROWS + 1);

  state_e           state_q;
  state_e           state_d;
  logic [PIX_W-1:0] pix_d;
  logic [ROW_W-1:0] row_d;
  logic             drop_q;
  logic             drop_rise_c;
  logic             tick_clear_c;
  logic             tick_en_c;
  logic             expire_c;

  // Drop edge detect and timer controls decoded from the current state.
  always_comb begin
    drop_rise_c  = drop && !drop_q;
    tick_clear_c = (state_q == S_TICK_RST);
    tick_en_c    = (state_q == S_WAIT);
  end

  stack_tick_timer #(
    .FRAME_TICKS (FRAME_TICKS),
    .TICK_STEP   (TICK_STEP),
    .MIN_TICKS   (MIN_TICKS),
    .ROW_W       (ROW_W)
  ) u_tick_timer (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (tick_clear_c),
    .en       (tick_en_c),
    .row      (row),
    .expire_c (expire_c)
  );

  // Next-state, next pixel offset and next row count.
  always_comb begin
    state_d = state_q;
    pix_d   = '0;
    row_d   = row;
    case (state_q)
      S_IDLE:     if (start) state_d = S_ARM;
      S_ARM:      if (!start) state_d = S_DRAW;
      S_DRAW: begin
        if (pix_idx == PIX_W'(BLOCK_PIXELS - 1)) state_d = S_TICK_RST;
        else                                      pix_d   = pix_idx + PIX_W'(1);
      end
      S_TICK_RST: state_d = S_WAIT;
      S_WAIT: begin
        // Drop outranks a coincident tick expiry.
        if (drop_rise_c)   state_d = S_CHECK;
        else if (expire_c) state_d = S_ERASE;
      end
      S_CHECK:    state_d = miss ? S_LOSE : S_HOLD;
      S_HOLD:     if (!drop) state_d = S_NEXT_ROW;
      S_ERASE: begin
        if (pix_idx == PIX_W'(BLOCK_PIXELS - 1)) state_d = S_LOAD;
        else                                      pix_d   = pix_idx + PIX_W'(1);
      end
      S_LOAD:     if (load_done) state_d = S_DRAW;
      S_NEXT_ROW: begin
        row_d   = row + ROW_W'(1);
        state_d = (row_d == ROW_W'(ROWS)) ? S_WIN : S_LOAD;
      end
      S_WIN:      state_d = S_WIN;
      S_LOSE:     state_d = S_LOSE;
      default:    state_d = S_IDLE;
    endcase
  end

  // State, counters and outputs registered together so outputs track the state.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q   <= S_IDLE;
      pix_idx   <= '0;
      row       <= '0;
      drop_q    <= 1'b0;
      write_en  <= 1'b0;
      erase     <= 1'b0;
      ld_xy     <= 1'b0;
      win       <= 1'b0;
      lose      <= 1'b0;
      state_led <= state_led_f(S_IDLE);
    end else begin
      state_q   <= state_d;
      pix_idx   <= pix_d;
      row       <= row_d;
      drop_q    <= drop;
      write_en  <= (state_d == S_DRAW) || (state_d == S_ERASE);
      erase     <= (state_d == S_ERASE);
      ld_xy     <= (state_d == S_LOAD);
      win       <= (state_d == S_WIN);
      lose      <= (state_d == S_LOSE);
      state_led <= state_led_f(state_d);
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Scoreboard bench for stack_sequencer: pixel writes checked against a queue of expected writes.
module tb_stack_sequencer;

  localparam int unsigned BP = 16;

  localparam logic [11:0] L_IDLE  = 12'h001;
  localparam logic [11:0] L_ARM   = 12'h002;
  localparam logic [11:0] L_DRAW  = 12'h004;
  localparam logic [11:0] L_TICK  = 12'h008;
  localparam logic [11:0] L_WAIT  = 12'h010;
  localparam logic [11:0] L_CHECK = 12'h020;
  localparam logic [11:0] L_HOLD  = 12'h040;
  localparam logic [11:0] L_ERASE = 12'h080;
  localparam logic [11:0] L_LOAD  = 12'h100;
  localparam logic [11:0] L_NEXT  = 12'h200;
  localparam logic [11:0] L_WIN   = 12'h400;
  localparam logic [11:0] L_LOSE  = 12'h800;

  logic        clk = 1'b0;
  logic        resetn, start, drop, miss, load_done;
  logic [3:0]  pix_idx, pix_idx4;
  logic        write_en, erase, ld_xy, win, lose;
  logic        write_en4, erase4, ld_xy4, win4, lose4;
  logic [3:0]  row;
  logic [2:0]  row4;
  logic [11:0] state_led, state_led4;

  typedef struct {
    logic [3:0] pix;
    logic       er;
  } px_t;

  px_t sb[$];
  px_t exp_px;
  int  checks = 0;
  int  failures = 0;
  int  post_win_we = 0;
  int  post_win_we4 = 0;

  always #5 clk = ~clk;

  stack_sequencer #(
    .BLOCK_PIXELS (16), .FRAME_TICKS (100), .TICK_STEP (10), .MIN_TICKS (40), .ROWS (8)
  ) u_dut (
    .clk (clk), .resetn (resetn), .start (start), .drop (drop), .miss (miss),
    .load_done (load_done), .pix_idx (pix_idx), .write_en (write_en), .erase (erase),
    .ld_xy (ld_xy), .row (row), .win (win), .lose (lose), .state_led (state_led)
  );

  stack_sequencer #(
    .BLOCK_PIXELS (16), .FRAME_TICKS (100), .TICK_STEP (10), .MIN_TICKS (40), .ROWS (4)
  ) u_dut4 (
    .clk (clk), .resetn (resetn), .start (start), .drop (drop), .miss (miss),
    .load_done (load_done), .pix_idx (pix_idx4), .write_en (write_en4), .erase (erase4),
    .ld_xy (ld_xy4), .row (row4), .win (win4), .lose (lose4), .state_led (state_led4)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Pixel-write scoreboard and post-win write monitors.
  always @(negedge clk) begin
    if (write_en) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected_write", 64'(write_en), 64'd0);
      end else begin
        exp_px = sb.pop_front();
        check_eq("sb_pix_idx", 64'(pix_idx), 64'(exp_px.pix));
        check_eq("sb_erase", 64'(erase), 64'(exp_px.er));
      end
    end
    if (win && write_en)   post_win_we++;
    if (win4 && write_en4) post_win_we4++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_led(input string tag, input logic [11:0] tgt, input int budget);
    int n = 0;
    while (state_led !== tgt && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, 64'(state_led), 64'(tgt));
  endtask

  task automatic push_blk(input logic er);
    for (int i = 0; i < int'(BP); i++) sb.push_back('{pix: 4'(i), er: er});
  endtask

  task automatic draw_phase();
    int n = 0;
    check_eq("draw_entry", 64'(state_led), 64'(L_DRAW));
    while (state_led === L_DRAW && n < 64) begin
      tick();
      n++;
    end
    check_eq("draw_len", 64'(n), 64'(BP));
    check_eq("after_draw", 64'(state_led), 64'(L_TICK));
    tick();
    check_eq("wait_entry", 64'(state_led), 64'(L_WAIT));
  endtask

  task automatic start_game();
    start = 1'b1;
    tick();
    check_eq("arm", 64'(state_led), 64'(L_ARM));
    tick();
    push_blk(1'b0);
    start = 1'b0;
    tick();
    draw_phase();
  endtask

  task automatic do_load();
    check_eq("load_state", 64'(state_led), 64'(L_LOAD));
    check_eq("ld_xy", 64'(ld_xy), 64'd1);
    tick();
    check_eq("load_hold", 64'(state_led), 64'(L_LOAD));
    push_blk(1'b0);
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    draw_phase();
  endtask

  task automatic expire_round(input int exp_per);
    int n = 0;
    push_blk(1'b1);
    while (state_led !== L_ERASE && n < 1000) begin
      tick();
      n++;
    end
    check_eq("period", 64'(n), 64'(exp_per));
    n = 0;
    while (state_led === L_ERASE && n < 64) begin
      tick();
      n++;
    end
    check_eq("erase_len", 64'(n), 64'(BP));
    do_load();
  endtask

  task automatic drop_round(input int at_n, input logic mv);
    repeat (at_n) tick();
    miss = mv;
    drop = 1'b1;
    tick();
    check_eq("check_state", 64'(state_led), 64'(L_CHECK));
    tick();
    if (mv) begin
      check_eq("lose_state", 64'(state_led), 64'(L_LOSE));
      check_eq("lose_flag", 64'(lose), 64'd1);
    end else begin
      check_eq("hold_state", 64'(state_led), 64'(L_HOLD));
      tick();
      check_eq("hold_while_drop", 64'(state_led), 64'(L_HOLD));
      drop = 1'b0;
      tick();
      check_eq("next_row_state", 64'(state_led), 64'(L_NEXT));
      tick();
    end
    miss = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
    check_eq("rst_state", 64'(state_led), 64'(L_IDLE));
    check_eq("rst_row", 64'(row), 64'd0);
    check_eq("rst_win_lose", 64'({win, lose}), 64'd0);
    sb.delete();
    tick();
  endtask

  initial begin
    resetn = 1'b1; start = 1'b0; drop = 1'b0; miss = 1'b0; load_done = 1'b0;
    repeat (3) tick();
    check_eq("reset_led", 64'(state_led), 64'(L_IDLE));
    check_eq("reset_outs", 64'({write_en, erase, ld_xy, win, lose}), 64'd0);
    check_eq("reset_pix", 64'(pix_idx), 64'd0);
    check_eq("reset_row", 64'(row), 64'd0);
    check_eq("reset_led4", 64'(state_led4), 64'(L_IDLE));
    resetn = 1'b0;
    tick();
    check_eq("idle_stays", 64'(state_led), 64'(L_IDLE));

    // Game 1: timed erase, coincident drop/expiry, then clean drops to a win.
    start_game();
    expire_round(100);
    drop_round(99, 1'b0);
    check_eq("row_after_drop", 64'(row), 64'd1);
    do_load();
    for (int r = 2; r <= 7; r++) begin
      drop_round(5, 1'b0);
      check_eq("row_after_drop", 64'(row), 64'(r));
      if (r == 4) begin
        check_eq("dut4_win_state", 64'(state_led4), 64'(L_WIN));
        check_eq("dut4_win_flag", 64'(win4), 64'd1);
        check_eq("dut4_row", 64'(row4), 64'd4);
      end
      do_load();
    end
    expire_round(40);
    drop_round(5, 1'b0);
    check_eq("win_row", 64'(row), 64'd8);
    check_eq("win_state", 64'(state_led), 64'(L_WIN));
    check_eq("win_flags", 64'({win, lose}), 64'd2);
    for (int i = 0; i < 30; i++) begin
      drop = (i % 8) >= 4;
      tick();
    end
    drop = 1'b0;
    check_eq("win_absorbing", 64'(state_led), 64'(L_WIN));
    check_eq("post_win_writes", 64'(post_win_we), 64'd0);
    check_eq("post_win_writes4", 64'(post_win_we4), 64'd0);
    check_eq("dut4_still_win", 64'({win4, state_led4}), 64'({1'b1, L_WIN}));
    check_eq("sb_drained", 64'(sb.size()), 64'd0);

    // Game 2: a miss loses; a held or repeated drop never re-enters CHECK.
    do_reset();
    start_game();
    drop_round(3, 1'b1);
    begin
      int n_chk = 0;
      repeat (10) begin
        tick();
        if (state_led === L_CHECK) n_chk++;
      end
      check_eq("held_drop_checks", 64'(n_chk), 64'd0);
    end
    check_eq("lose_held", 64'({lose, state_led}), 64'({1'b1, L_LOSE}));
    drop = 1'b0;
    tick();
    drop = 1'b1;
    tick();
    tick();
    check_eq("lose_absorbing", 64'({lose, win, state_led}), 64'({1'b1, 1'b0, L_LOSE}));
    drop = 1'b0;

    // Game 3: reset in the middle of an erase.
    do_reset();
    start_game();
    drop_round(5, 1'b0);
    check_eq("g3_row", 64'(row), 64'd1);
    do_load();
    push_blk(1'b1);
    wait_led("erase_entry", L_ERASE, 200);
    repeat (5) tick();
    check_eq("mid_erase_we", 64'({write_en, erase}), 64'd3);
    resetn = 1'b1;
    tick();
    check_eq("rst_mid_erase_state", 64'(state_led), 64'(L_IDLE));
    check_eq("rst_mid_erase_we", 64'({write_en, erase, ld_xy}), 64'd0);
    check_eq("rst_mid_erase_row", 64'(row), 64'd0);
    check_eq("rst_mid_erase_pix", 64'(pix_idx), 64'd0);
    resetn = 1'b0;
    sb.delete();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/stack_sequencer.md
STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 SHALL have parameter BLOCK_PIXELS, default 16: pixel writes per block draw or erase.
REQ-002 SHALL have parameter FRAME_TICKS, default 2_500_000: move period at row 0, in clk cycles.
REQ-003 SHALL have parameter TICK_STEP, default 250_000: period reduction per completed row.
REQ-004 SHALL have parameter MIN_TICKS, default 500_000: floor on the move period.
REQ-005 SHALL have parameter ROWS, default 8: rows to win.
REQ-006 SHALL have ports: clk  in  1  system clock (one clock; reset is synchronous and active-high).
REQ-007 SHALL have ports: resetn  in  1  synchronous active-high reset.
REQ-008 SHALL have ports: start  in  1  level; press then release begins a game.
REQ-009 SHALL have ports: drop  in  1  level; player places the block.
REQ-010 SHALL have ports: miss  in  1  datapath flag: placed block has no overlap with the row below.
REQ-011 SHALL have ports: load_done  in  1  datapath has finished updating x/y.
REQ-012 SHALL have ports: pix_idx  out  clog2(BLOCK_PIXELS)  pixel offset for the current write.
REQ-013 SHALL have ports: write_en  out  1  VGA plot strobe.
REQ-014 SHALL have ports: erase  out  1  selects the background colour.
REQ-015 SHALL have ports: ld_xy  out  1  datapath load request.
REQ-016 SHALL have ports: row  out  clog2(ROWS+1)  completed-row count.
REQ-017 SHALL have ports: win, lose  out  1 each  sticky game result.
REQ-018 SHALL have ports: state_led  out  12  one-hot current state, for debug.

Function
REQ-019 SHALL implement states IDLE, ARM, DRAW, TICK_RST, WAIT, CHECK, HOLD, ERASE, LOAD, NEXT_ROW, WIN, LOSE.
REQ-020 SHALL go IDLE->ARM while start=1, and ARM->DRAW on the first cycle with start=0.
REQ-021 SHALL hold DRAW for exactly BLOCK_PIXELS cycles, with write_en=1 and pix_idx=0..BLOCK_PIXELS-1 in order, then go to TICK_RST.
REQ-022 SHALL hold ERASE for exactly BLOCK_PIXELS cycles with write_en=1 and erase=1, then go to LOAD.
REQ-023 SHALL make TICK_RST last one cycle, clearing the tick counter, then go to WAIT.
REQ-024 SHALL use period = max(FRAME_TICKS - row*TICK_STEP, MIN_TICKS), computed at full width without underflow.
REQ-025 SHALL go from WAIT to ERASE when the tick count reaches period-1.
REQ-026 SHALL go from WAIT to CHECK in the cycle after a rising edge of drop is detected, using a registered edge detector.
REQ-027 SHALL give drop priority when drop and tick expiry coincide.
REQ-028 SHALL go CHECK->LOSE if miss=1, else CHECK->HOLD.
REQ-029 SHALL wait in HOLD until drop=0, then go to NEXT_ROW.
REQ-030 SHALL increment row in NEXT_ROW, then go to WIN if row becomes ROWS, else go to LOAD.
REQ-031 SHALL assert ld_xy=1 in LOAD and go to DRAW when load_done=1.
REQ-032 SHALL make WIN and LOSE absorbing until reset, with win/lose held at 1.
REQ-033 SHALL drive write_en, erase and ld_xy low in every state not listed above; pix_idx SHALL be 0 outside DRAW and ERASE.

Reset
REQ-034 SHALL put the block in IDLE in the cycle after resetn=1, from any state including mid-DRAW.
REQ-035 SHALL clear the tick counter, pixel counter, row, edge register, win and lose on reset.
REQ-036 SHALL hold all outputs at 0 after reset, except state_led=IDLE.

Structure
REQ-037 SHALL define the state enum and its state_led encoding in shared package stack_pkg.
REQ-038 SHALL use one sub-module, stack_tick_timer, holding the period computation and the tick counter, with clear and expire signals.

Verification
REQ-039 SHALL verify, with BLOCK_PIXELS=16: start pulse -> DRAW for 16 cycles, pix_idx 0..15, then TICK_RST.
REQ-040 SHALL verify, with FRAME_TICKS=100, TICK_STEP=10, MIN_TICKS=40 and no drop: ERASE entered 100 cycles after WAIT entry, then LOAD, then DRAW after load_done.
REQ-041 SHALL verify, with the same parameters after 7 clean drops: period is 40, not 30.
REQ-042 SHALL verify, with ROWS=4: four drops with miss=0 -> row=4 and win=1, then no further write_en.
REQ-043 SHALL verify: drop with miss=1 -> LOSE, lose=1 held, and a held drop causes no second CHECK.
REQ-044 SHALL verify: drop and tick expiry in the same cycle -> CHECK taken; resetn=1 mid-ERASE -> IDLE next cycle, with write_en=0 and row=0.
